gun_aim_ctrl: RTL and testbench

//  Sequences the 6-bit light-gun H/V position registers fed to williams2 (gun_h/gun_v) from digital joystick directions.

---
 rtl/gun_aim_if.sv | 25 ++
 rtl/gun_aim_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gun_aim_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gun_aim_if.sv
// Joystick-to-gun handshake bundle between the emu top level and gun_aim_ctrl.
// The master drives tick and buttons; the slave returns the registered gun position.
interface gun_aim_if #(
  parameter int POS_W = 6
);
  logic             tick_4ms;
  logic             btn_left;
  logic             btn_right;
  logic             btn_up;
  logic             btn_down;
  logic             recenter;
  logic [POS_W-1:0] gun_h;
  logic [POS_W-1:0] gun_v;
  logic             moving;

  modport master (
    output tick_4ms, btn_left, btn_right, btn_up, btn_down, recenter,
    input  gun_h, gun_v, moving
  );

  modport slave (
    input  tick_4ms, btn_left, btn_right, btn_up, btn_down, recenter,
    output gun_h, gun_v, moving
  );
endinterface

// File: rtl/gun_aim_ctrl.sv
// Light-gun H/V position sequencer: tap/hold/auto-repeat per axis, stepped on 4 ms tick edges.
// Optional macro GUN_ACCEL_EN doubles the repeat step after ACCEL_AFTER repeat steps.
module gun_aim_ctrl #(
  parameter int POS_W       = 6,
  parameter int POS_MAX     = 63,
  parameter int POS_INIT    = 32,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_DIV  = 2,
  parameter int ACCEL_AFTER = 16
) (
  input  logic     clock_12,
  input  logic     reset,
  gun_aim_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b11;

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_DIV) ? REPEAT_DLY : REPEAT_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
`ifdef GUN_ACCEL_EN
  localparam int ACC_W   = $clog2(ACCEL_AFTER + 1);
`endif

  if (REPEAT_DLY < 1 || REPEAT_DIV < 1 || ACCEL_AFTER < 1) begin : g_param_err
    $error("gun_aim_ctrl: REPEAT_DLY, REPEAT_DIV and ACCEL_AFTER must be >= 1");
  end

  typedef struct packed {
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       dir;   // direction of the most recent step
    logic [POS_W-1:0] pos;
`ifdef GUN_ACCEL_EN
    logic [ACC_W-1:0] acc;
`endif
  } axis_t;

  function automatic axis_t axis_reset();
    axis_t r;
    r.st  = ST_IDLE;
    r.cnt = '0;
    r.dir = DIR_NONE;
    r.pos = POS_W'(POS_INIT);
`ifdef GUN_ACCEL_EN
    r.acc = '0;
`endif
    return r;
  endfunction

  // NOTE: nx starts as a full copy of cur, so every field has a value on every path and no latch can form.
  function automatic axis_t axis_next(input axis_t cur, input logic neg, input logic pos);
    axis_t          nx;
    logic [1:0]     dir;
    logic           do_step;
    logic [POS_W:0] size;
    logic [POS_W:0] ext;
    logic [POS_W:0] sum;
    nx      = cur;
    do_step = 1'b0;
    size    = (POS_W+1)'(1);
    dir     = (pos & ~neg) ? DIR_POS : ((neg & ~pos) ? DIR_NEG : DIR_NONE);

    case (cur.st)
      ST_HOLD: begin
        if (dir == DIR_NONE) begin
          nx.st  = ST_IDLE;
          nx.cnt = '0;
        end else if (dir != cur.dir) begin
          do_step = 1'b1;
          nx.cnt  = '0;
        end else if (cur.cnt == CNT_W'(REPEAT_DLY - 1)) begin
          do_step = 1'b1;
          nx.cnt  = '0;
          nx.st   = ST_REPEAT;
        end else begin
          nx.cnt = cur.cnt + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (dir == DIR_NONE) begin
          nx.st  = ST_IDLE;
          nx.cnt = '0;
        end else if (dir != cur.dir) begin
          do_step = 1'b1;
          nx.cnt  = '0;
          nx.st   = ST_HOLD;
        end else if (cur.cnt == CNT_W'(REPEAT_DIV - 1)) begin
          do_step = 1'b1;
          nx.cnt  = '0;
`ifdef GUN_ACCEL_EN
          if (cur.acc == ACC_W'(ACCEL_AFTER)) size = (POS_W+1)'(2);
          else                                nx.acc = cur.acc + ACC_W'(1);
`endif
        end else begin
          nx.cnt = cur.cnt + CNT_W'(1);
        end
      end
      default: begin  // IDLE, and recovery from the unused encoding
        nx.cnt = '0;
        nx.st  = ST_IDLE;
        if (dir != DIR_NONE) begin
          do_step = 1'b1;
          nx.st   = ST_HOLD;
        end
      end
    endcase

`ifdef GUN_ACCEL_EN
    if (nx.st != ST_REPEAT) nx.acc = '0;
`endif

    // Step is widened by one bit so both limits are detected before truncation.
    if (do_step) begin
      ext = {1'b0, cur.pos};
      if (dir == DIR_POS) begin
        sum    = ext + size;
        nx.pos = (sum > (POS_W+1)'(POS_MAX)) ? POS_W'(POS_MAX) : sum[POS_W-1:0];
      end else begin
        sum    = ext - size;
        nx.pos = (ext < size) ? '0 : sum[POS_W-1:0];
      end
      nx.dir = dir;
    end
    return nx;
  endfunction

  logic  tick_r;
  logic  tick_rise;
  logic  moving_q;
  axis_t ax_h;
  axis_t ax_v;
  axis_t h_nxt;
  axis_t v_nxt;

  assign tick_rise = bus.tick_4ms & ~tick_r;
  assign h_nxt     = axis_next(ax_h, bus.btn_left, bus.btn_right);
  assign v_nxt     = axis_next(ax_v, bus.btn_up,   bus.btn_down);

  // NOTE: all state below is written with <= so every register samples pre-edge values.
  always_ff @(posedge clock_12) begin
    if (reset) begin
      tick_r   <= 1'b1;  // a tick already high at release is not an edge
      ax_h     <= axis_reset();
      ax_v     <= axis_reset();
      moving_q <= 1'b0;
    end else begin
      tick_r <= bus.tick_4ms;
      if (bus.recenter) begin
        ax_h     <= axis_reset();
        ax_v     <= axis_reset();
        moving_q <= 1'b0;
      end else if (tick_rise) begin
        ax_h     <= h_nxt;
        ax_v     <= v_nxt;
        moving_q <= (h_nxt.st != ST_IDLE) | (v_nxt.st != ST_IDLE);
      end
    end
  end

  assign bus.gun_h  = ax_h.pos;
  assign bus.gun_v  = ax_v.pos;
  assign bus.moving = moving_q;

endmodule

// File: tb/tb_gun_aim_ctrl.sv
// Self-checking bench for gun_aim_ctrl: directed scenarios plus a random phase,
// compared against a press-duration model of the tap/hold/repeat behaviour.
module tb_gun_aim_ctrl;

  localparam int POS_W      = 6;
  localparam int POS_MAX    = 63;
  localparam int POS_INIT   = 32;
  localparam int REPEAT_DLY = 8;
  localparam int REPEAT_DIV = 2;

  logic clock_12;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  gun_aim_if #(.POS_W(POS_W)) bus ();

  gun_aim_ctrl #(
    .POS_W      (POS_W),
    .POS_MAX    (POS_MAX),
    .POS_INIT   (POS_INIT),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_DIV (REPEAT_DIV),
    .ACCEL_AFTER(16)
  ) dut (
    .clock_12(clock_12),
    .reset   (reset),
    .bus     (bus)
  );

  initial clock_12 = 1'b0;
  always #5 clock_12 = ~clock_12;

  // Model: per axis, k = number of ticks the current direction has been held (0 = idle).
  // A step happens at k=1, at k=1+REPEAT_DLY, then every REPEAT_DIV ticks.
  int m_pos[2];
  int m_k[2];
  int m_dir[2];

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      m_pos[a] = POS_INIT;
      m_k[a]   = 0;
      m_dir[a] = 0;
    end
  endtask

  task automatic model_tick();
    int d[2];
    d[0] = int'(bus.btn_right) - int'(bus.btn_left);
    d[1] = int'(bus.btn_down)  - int'(bus.btn_up);
    for (int a = 0; a < 2; a++) begin
      if (d[a] == 0) begin
        m_k[a] = 0;
      end else begin
        if (m_k[a] == 0 || d[a] != m_dir[a]) m_k[a] = 1;
        else                                 m_k[a] = m_k[a] + 1;
        if (m_k[a] == 1 ||
            (m_k[a] >= REPEAT_DLY + 1 && (m_k[a] - REPEAT_DLY - 1) % REPEAT_DIV == 0)) begin
          m_pos[a] = m_pos[a] + d[a];
          if (m_pos[a] < 0)       m_pos[a] = 0;
          if (m_pos[a] > POS_MAX) m_pos[a] = POS_MAX;
        end
        m_dir[a] = d[a];
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gun_h"},  32'(bus.gun_h),  32'(m_pos[0]));
    check({tag, ".gun_v"},  32'(bus.gun_v),  32'(m_pos[1]));
    check({tag, ".moving"}, 32'(bus.moving), 32'(m_k[0] != 0 || m_k[1] != 0));
  endtask

  // Called at a negedge; one tick rising edge, returns at a negedge with outputs settled.
  task automatic pulse_tick();
    bus.tick_4ms = 1'b1;
    @(negedge clock_12);
    bus.tick_4ms = 1'b0;
    if (bus.recenter) model_reset();
    else              model_tick();
    @(negedge clock_12);
  endtask

  task automatic set_btns(input logic [3:0] lrud);
    {bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down} = lrud;
  endtask

  task automatic do_recenter();
    bus.recenter = 1'b1;
    @(negedge clock_12);
    bus.recenter = 1'b0;
    model_reset();
    @(negedge clock_12);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    model_reset();
    reset        = 1'b1;
    bus.tick_4ms = 1'b1;
    bus.recenter = 1'b0;
    set_btns(4'b0000);

    // Reset released while the tick is high: no edge must be seen.
    repeat (3) @(negedge clock_12);
    reset = 1'b0;
    repeat (3) @(negedge clock_12);
    check_all("reset");
    check("reset_h_const", 32'(bus.gun_h), 32);
    set_btns(4'b0100);
    repeat (4) @(negedge clock_12);
    check("tick_high_no_step", 32'(bus.gun_h), 32);
    check("tick_high_idle", 32'(bus.moving), 0);
    set_btns(4'b0000);
    bus.tick_4ms = 1'b0;
    repeat (2) @(negedge clock_12);
    check("tick_fall_no_step", 32'(bus.gun_h), 32);

    // Tap then hold right: steps at ticks 1, 9, 11, 13.
    set_btns(4'b0100);
    for (int t = 1; t <= 13; t++) begin
      pulse_tick();
      check_all("hold_right");
      case (t)
        1:  check("hold_t1",  32'(bus.gun_h), 33);
        8:  check("hold_t8",  32'(bus.gun_h), 33);
        9:  check("hold_t9",  32'(bus.gun_h), 34);
        11: check("hold_t11", 32'(bus.gun_h), 35);
        13: check("hold_t13", 32'(bus.gun_h), 36);
        default: ;
      endcase
    end
    check("hold_moving", 32'(bus.moving), 1);
    set_btns(4'b0000);
    pulse_tick();
    check("release_moving", 32'(bus.moving), 0);
    check("release_keep_h", 32'(bus.gun_h), 36);

    // Saturation at both limits.
    set_btns(4'b1000);
    for (int t = 0; t < 200; t++) begin
      pulse_tick();
      check_all("sat_low");
    end
    check("sat_low_zero", 32'(bus.gun_h), 0);
    set_btns(4'b0001);
    for (int t = 0; t < 200; t++) begin
      pulse_tick();
      check_all("sat_high");
    end
    check("sat_high_63", 32'(bus.gun_v), 63);
    set_btns(4'b0000);
    pulse_tick();
    check_all("sat_release");

    // Left+right cancel while up moves V independently.
    do_recenter();
    check_all("recenter_plain");
    set_btns(4'b1110);
    pulse_tick();
    check("cancel_h", 32'(bus.gun_h), 32);
    check("indep_v", 32'(bus.gun_v), 31);
    for (int t = 0; t < 3; t++) begin
      pulse_tick();
      check_all("cancel_hold");
    end
    set_btns(4'b1100);
    pulse_tick();
    check("cancel_h_idle", 32'(bus.moving), 0);
    check("cancel_h_keep", 32'(bus.gun_h), 32);
    set_btns(4'b0000);

    // Recenter coinciding with a tick edge, with right held at 40.
    set_btns(4'b0100);
    for (int t = 0; t < 40 && m_pos[0] != 40; t++) begin
      pulse_tick();
      check_all("to_40");
    end
    check("at_40", 32'(bus.gun_h), 40);
    bus.recenter = 1'b1;
    pulse_tick();
    check("recenter_tick_h", 32'(bus.gun_h), 32);
    check("recenter_tick_idle", 32'(bus.moving), 0);
    pulse_tick();
    check("recenter_held_h", 32'(bus.gun_h), 32);
    bus.recenter = 1'b0;
    pulse_tick();
    check("after_recenter_h", 32'(bus.gun_h), 33);
    check_all("after_recenter");

    // Reset in the middle of a hold: the held button steps on the first tick after.
    for (int t = 0; t < 5; t++) pulse_tick();
    reset = 1'b1;
    repeat (2) @(negedge clock_12);
    reset = 1'b0;
    model_reset();
    @(negedge clock_12);
    check_all("midhold_reset");
    pulse_tick();
    check("midhold_first_tick", 32'(bus.gun_h), 33);
    check_all("midhold_tick");
    set_btns(4'b0000);
    pulse_tick();

    // Random buttons with occasional recenter.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(11) == 0) set_btns(4'($urandom_range(15)));
      bus.recenter = ($urandom_range(39) == 0);
      pulse_tick();
      bus.recenter = 1'b0;
      check_all("random");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
